// File: rtl/lcd_cmd_sequencer_if.sv
// Bus between the display controller, command ROM and SPI byte sender on one side
// and the ROM-driven command sequencer on the other.
interface lcd_cmd_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic          i_start;
  logic [AW-1:0] i_base;
  logic          i_abort;
  logic [AW-1:0] o_rom_addr;
  logic [DW+1:0] i_rom_data;
  logic          o_send;
  logic [DW-1:0] o_data;
  logic          o_dc;
  logic          o_cs;
  logic          i_byte_done;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  modport slave (
    input  i_start, i_base, i_abort, i_rom_data, i_byte_done,
    output o_rom_addr, o_send, o_data, o_dc, o_cs, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_base, i_abort, i_rom_data, i_byte_done,
    input  o_rom_addr, o_send, o_data, o_dc, o_cs, o_busy, o_done, o_err
  );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// ILI9341 command sequencer: walks a command ROM from a base address, sending bytes,
// executing timed delays and stopping at an end marker or on address overrun.
module lcd_cmd_sequencer #(
  parameter int DW         = 8,
  parameter int AW         = 6,
  parameter int GAP_CYCLES = 8,
  parameter int DELAY_UNIT = 1000
) (
  input logic               clk,
  input logic               rst,
  lcd_cmd_sequencer_if.slave bus
);
  localparam int CW_D = DW + $clog2(DELAY_UNIT) + 1;
  localparam int CW_G = $clog2(GAP_CYCLES + 1) + 1;
  localparam int CW   = (CW_D > CW_G) ? CW_D : CW_G;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, SEND, WAIT_TX, GAP, DELAY, DONE, ERR
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] addr, addr_n;
  logic [DW-1:0] data, data_n;
  logic          dc, dc_n, cs, cs_n;
  logic          send, send_n, busy, busy_n, done, done_n, err, err_n;
  logic          adv;
  logic          ent_type, ent_dc;
  logic [DW-1:0] ent_pay;

  assign {ent_type, ent_dc, ent_pay} = bus.i_rom_data;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    data_n  = data;
    dc_n    = dc;
    cs_n    = cs;
    send_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          addr_n  = bus.i_base;
          state_n = FETCH;
        end
      end
      FETCH: state_n = DECODE;
      DECODE: begin
        if (!ent_type) begin
          data_n  = ent_pay;
          dc_n    = ent_dc;
          send_n  = 1'b1;
          cs_n    = 1'b0;
          state_n = SEND;
        end else if (ent_pay != '0) begin
          cs_n    = 1'b1;
          cnt_n   = CW'(ent_pay) * CW'(DELAY_UNIT) - CW'(1);
          state_n = DELAY;
        end else begin
          done_n  = 1'b1;
          cs_n    = 1'b1;
          dc_n    = 1'b1;
          state_n = DONE;
        end
      end
      SEND: state_n = WAIT_TX;
      WAIT_TX: begin
        if (bus.i_byte_done) begin
          if (GAP_CYCLES == 0) begin
            adv = 1'b1;
          end else begin
            cnt_n   = CW'(GAP_CYCLES - 1);
            state_n = GAP;
          end
        end
      end
      GAP, DELAY: begin
        if (cnt == '0) adv = 1'b1;
        else           cnt_n = cnt - CW'(1);
      end
      DONE, ERR: state_n = IDLE;
      default:   state_n = IDLE;
    endcase

    // Last ROM address never wraps: running past it is an overrun.
    if (adv) begin
      if (addr == '1) begin
        err_n   = 1'b1;
        cs_n    = 1'b1;
        state_n = ERR;
      end else begin
        addr_n  = addr + AW'(1);
        state_n = FETCH;
      end
    end

    if (state != IDLE && bus.i_abort) begin
      state_n = IDLE;
      cs_n    = 1'b1;
      send_n  = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      data  <= '0;
      dc    <= 1'b1;
      cs    <= 1'b1;
      send  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      addr  <= addr_n;
      data  <= data_n;
      dc    <= dc_n;
      cs    <= cs_n;
      send  <= send_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  assign bus.o_rom_addr = addr;
  assign bus.o_send     = send;
  assign bus.o_data     = data;
  assign bus.o_dc       = dc;
  assign bus.o_cs       = cs;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_err      = err;
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer: byte/delay/end decode, gap timing, abort,
// overrun, ignored starts and asynchronous reset.
module tb_lcd_cmd_sequencer;
  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int GAP = 8;
  localparam int DU  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_cmd_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  lcd_cmd_sequencer #(
    .DW(DW), .AW(AW), .GAP_CYCLES(GAP), .DELAY_UNIT(DU)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW+1:0] rom [2**AW];
  logic [DW+1:0] rom_q;
  always @(posedge clk) rom_q <= rom[bus.o_rom_addr];
  assign bus.i_rom_data = rom_q;

  int send_cnt = 0, done_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    if (bus.o_send) send_cnt++;
    if (bus.o_done) done_cnt++;
    if (bus.o_err)  err_cnt++;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.o_send;
      1:       return bus.o_done;
      default: return bus.o_err;
    endcase
  endfunction

  // Returns the number of ticks until the selected pulse, or -1 on timeout.
  task automatic wait_for(input int sel, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (sig(sel)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic start(input int base);
    bus.i_base  = AW'(base);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic byte_done();
    bus.i_byte_done = 1'b1;
    tick();
    bus.i_byte_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  int n, s0, d0, e0;

  initial begin
    for (int i = 0; i < 2**AW; i++) rom[i] = {2'b10, {DW{1'b0}}};
    rom[4]  = 10'h02A; rom[5]  = 10'h100; rom[6]  = 10'h200;
    rom[9]  = 10'h011; rom[10] = 10'h203; rom[11] = 10'h055; rom[12] = 10'h200;
    rom[62] = 10'h0A1; rom[63] = 10'h1B2;
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_byte_done = 1'b0; bus.i_base = '0;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_send", bus.o_send, 0);
    check("rst_data", bus.o_data, 0);
    check("rst_dc",   bus.o_dc, 1);
    check("rst_cs",   bus.o_cs, 1);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_err",  bus.o_err, 0);
    check("rst_addr", bus.o_rom_addr, 0);
    rst = 1'b1;

    // Two bytes then end marker; first byte_done held off 20 cycles.
    tick();
    d0 = done_cnt;
    start(4);
    check("t1_c1_addr", bus.o_rom_addr, 4);
    check("t1_c1_busy", bus.o_busy, 1);
    check("t1_c1_send", bus.o_send, 0);
    tick();
    check("t1_c2_send", bus.o_send, 0);
    tick();
    check("t1_c3_send", bus.o_send, 1);
    check("t1_c3_data", bus.o_data, 8'h2A);
    check("t1_c3_dc",   bus.o_dc, 0);
    check("t1_c3_cs",   bus.o_cs, 0);
    tick();
    check("t1_send_1cyc", bus.o_send, 0);
    s0 = send_cnt;
    repeat (20) tick();
    check("t3_hold_nosend", send_cnt - s0, 0);
    check("t3_hold_busy", bus.o_busy, 1);
    check("t3_hold_cs", bus.o_cs, 0);
    byte_done();
    check("t3_cs_gap", bus.o_cs, 0);
    wait_for(0, 30, n);
    check("t3_gap_lat", n, 10);
    check("t1_b2_data", bus.o_data, 8'h00);
    check("t1_b2_dc", bus.o_dc, 1);
    tick();
    byte_done();
    wait_for(1, 30, n);
    check("t1_done_lat", n, 10);
    check("t1_done_cs", bus.o_cs, 1);
    check("t1_done_dc", bus.o_dc, 1);
    check("t1_done_busy", bus.o_busy, 1);
    tick();
    check("t1_idle_busy", bus.o_busy, 0);
    check("t1_idle_cs", bus.o_cs, 1);
    check("t1_done_once", done_cnt - d0, 1);

    // Byte, then delay of 3 units (30 cycles), then byte, then end.
    tick();
    start(9);
    wait_for(0, 10, n);
    check("t2_first_lat", n, 2);
    check("t2_first_data", bus.o_data, 8'h11);
    tick();
    byte_done();
    repeat (9) tick();
    check("t2_decode_cs", bus.o_cs, 0);
    tick();
    check("t2_delay_cs", bus.o_cs, 1);
    check("t2_delay_addr", bus.o_rom_addr, 10);
    repeat (29) tick();
    check("t2_delay_last_addr", bus.o_rom_addr, 10);
    check("t2_delay_last_cs", bus.o_cs, 1);
    tick();
    check("t2_fetch_addr", bus.o_rom_addr, 11);
    wait_for(0, 5, n);
    check("t2_resume_lat", n, 2);
    check("t2_resume_data", bus.o_data, 8'h55);
    check("t2_resume_cs", bus.o_cs, 0);
    tick();
    byte_done();
    wait_for(1, 30, n);
    check("t2_done_lat", n, 10);
    tick();

    // Abort while waiting for the SPI sender.
    tick();
    start(4);
    wait_for(0, 5, n);
    check("t4_send_lat", n, 2);
    tick();
    d0 = done_cnt;
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check("t4_abort_busy", bus.o_busy, 0);
    check("t4_abort_cs", bus.o_cs, 1);
    check("t4_abort_send", bus.o_send, 0);
    byte_done();
    s0 = send_cnt;
    repeat (15) tick();
    check("t4_late_nosend", send_cnt - s0, 0);
    check("t4_late_busy", bus.o_busy, 0);
    check("t4_no_done", done_cnt - d0, 0);

    // No end marker before the top of the ROM.
    tick();
    d0 = done_cnt;
    e0 = err_cnt;
    start(62);
    wait_for(0, 5, n);
    check("t5_b1_lat", n, 2);
    check("t5_b1_data", bus.o_data, 8'hA1);
    tick();
    byte_done();
    wait_for(0, 30, n);
    check("t5_b2_lat", n, 10);
    check("t5_b2_data", bus.o_data, 8'hB2);
    check("t5_b2_dc", bus.o_dc, 1);
    check("t5_b2_addr", bus.o_rom_addr, 63);
    tick();
    byte_done();
    wait_for(2, 30, n);
    check("t5_err_lat", n, 8);
    check("t5_err_cs", bus.o_cs, 1);
    check("t5_err_addr", bus.o_rom_addr, 63);
    tick();
    check("t5_idle_busy", bus.o_busy, 0);
    check("t5_err_once", err_cnt - e0, 1);
    check("t5_no_done", done_cnt - d0, 0);

    // Starts while busy are ignored.
    tick();
    start(4);
    wait_for(0, 5, n);
    check("t6_send_lat", n, 2);
    tick();
    bus.i_base  = AW'(10);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("t6_busy_start_addr", bus.o_rom_addr, 4);
    check("t6_busy_start_busy", bus.o_busy, 1);
    byte_done();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_for(0, 30, n);
    check("t6_gap_start_lat", n, 9);
    check("t6_gap_start_data", bus.o_data, 8'h00);
    check("t6_gap_start_addr", bus.o_rom_addr, 5);
    tick();
    byte_done();
    wait_for(1, 30, n);
    check("t6_done_lat", n, 10);
    tick();

    // Start with abort in IDLE: abort wins.
    bus.i_base  = AW'(9);
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    tick();
    check("t6_startabort_busy", bus.o_busy, 0);
    check("t6_startabort_addr", bus.o_rom_addr, 6);

    // Asynchronous reset in the middle of a delay.
    tick();
    start(9);
    wait_for(0, 5, n);
    check("t6_rst_send_lat", n, 2);
    tick();
    byte_done();
    repeat (14) tick();
    check("t6_pre_cs", bus.o_cs, 1);
    check("t6_pre_dc", bus.o_dc, 0);
    check("t6_pre_data", bus.o_data, 8'h11);
    rst = 1'b0;
    #1;
    check("t6_arst_addr", bus.o_rom_addr, 0);
    check("t6_arst_data", bus.o_data, 0);
    check("t6_arst_dc", bus.o_dc, 1);
    check("t6_arst_cs", bus.o_cs, 1);
    check("t6_arst_busy", bus.o_busy, 0);
    check("t6_arst_send", bus.o_send, 0);
    #1 rst = 1'b1;
    tick();
    check("t6_post_busy", bus.o_busy, 0);
    check("t6_post_addr", bus.o_rom_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
